display_rx: RTL and testbench

Receiving end of the calculator's serial display link. Deserializes 16-bit BCD frames (4 digits) shifted in on `data_in` / `data_clk` and committed by `data_ready`. Validates the bit count, holds the last good frame, and time-multiplexes it onto a 4-digit 7-segment display. Runs in the board/display domain on a single free-running clock, oversampling the link signals.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/display_rx_if.sv | 25 ++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/display_rx.sv | 139 +++++++++++++
 tb/tb_display_rx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator display definitions: frame geometry and 7-segment patterns.
// Segment patterns are ordered {g,f,e,d,c,b,a}, active-high.
package calc_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned BCD_DIGITS = 4;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b0111111;
   localparam seg_t SEG_1     = 7'b0000110;
   localparam seg_t SEG_2     = 7'b1011011;
   localparam seg_t SEG_3     = 7'b1001111;
   localparam seg_t SEG_4     = 7'b1100110;
   localparam seg_t SEG_5     = 7'b1101101;
   localparam seg_t SEG_6     = 7'b1111101;
   localparam seg_t SEG_7     = 7'b0000111;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1101111;
   localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/display_rx_if.sv
// Serial display link plus the decoded frame/scan outputs of the receiver.
interface display_rx_if #(
   parameter int unsigned DIGITS = 4
) ();

   logic                  data_in;
   logic                  data_clk;
   logic                  data_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  frame_valid;
   logic                  frame_err;
   logic [6:0]            seg;
   logic [DIGITS-1:0]     dig_en;

   modport master (
      output data_in, data_clk, data_ready,
      input  bcd_out, frame_valid, frame_err, seg, dig_en
   );

   modport slave (
      input  data_in, data_clk, data_ready,
      output bcd_out, frame_valid, frame_err, seg, dig_en
   );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes blank the digit.
module bcd_to_7seg
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_rx.sv
// Display link receiver: oversamples the serial link, validates and holds BCD
// frames, and time-multiplexes the held frame onto a 7-segment display.
module display_rx
   import calc_pkg::*;
#(
   parameter int unsigned FRAME_BITS  = calc_pkg::FRAME_BITS,
   parameter int unsigned DIGITS      = calc_pkg::BCD_DIGITS,
   parameter int unsigned REFRESH_DIV = 16
) (
   input  logic          clk,
   input  logic          rst,
   display_rx_if.slave   link
);

   localparam int unsigned CW = $clog2(FRAME_BITS + 2);
   localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [2:0]            clk_sync;
   logic [2:0]            rdy_sync;
   logic [1:0]            din_sync;
   logic                  clk_rise_q;
   logic                  rdy_rise_q;
   logic                  bit_q;

   logic [FRAME_BITS-1:0] shift;
   logic [FRAME_BITS-1:0] shift_nxt;
   logic [CW-1:0]         bit_cnt;
   logic [CW-1:0]         cnt_nxt;
   logic [4*DIGITS-1:0]   bcd_r;
   logic                  valid_r;
   logic                  err_r;

   logic [RW-1:0]         ref_cnt;
   logic [IW-1:0]         idx;
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;
   logic [6:0]            seg_r;
   logic [DIGITS-1:0]     dig_nxt;
   logic [DIGITS-1:0]     dig_r;

   // Edge pulses are registered once more so a link edge first captured at
   // edge k is acted on at edge k+3; data_in travels with the same stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync   <= '0;
         rdy_sync   <= '0;
         din_sync   <= '0;
         clk_rise_q <= 1'b0;
         rdy_rise_q <= 1'b0;
         bit_q      <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[1:0], link.data_clk};
         rdy_sync   <= {rdy_sync[1:0], link.data_ready};
         din_sync   <= {din_sync[0], link.data_in};
         clk_rise_q <= clk_sync[1] & ~clk_sync[2];
         rdy_rise_q <= rdy_sync[1] & ~rdy_sync[2];
         bit_q      <= din_sync[1];
      end
   end

   // A shift coinciding with the commit is applied first and counted.
   always_comb begin
      shift_nxt = shift;
      cnt_nxt   = bit_cnt;
      if (clk_rise_q) begin
         shift_nxt = {shift[FRAME_BITS-2:0], bit_q};
         if (bit_cnt != CW'(FRAME_BITS + 1))
            cnt_nxt = bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift   <= '0;
         bit_cnt <= '0;
         bcd_r   <= '0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         shift   <= shift_nxt;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         if (rdy_rise_q) begin
            bit_cnt <= '0;
            if (cnt_nxt == CW'(FRAME_BITS)) begin
               bcd_r   <= shift_nxt;
               valid_r <= 1'b1;
            end else begin
               err_r   <= 1'b1;
            end
         end else begin
            bit_cnt <= cnt_nxt;
         end
      end
   end

   always_comb begin
      nibble = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (IW'(i) == idx)
            nibble = bcd_r[4*i +: 4];
   end

   always_comb begin
      dig_nxt      = '0;
      dig_nxt[idx] = 1'b1;
   end

   bcd_to_7seg u_dec (
      .bcd (nibble),
      .seg (seg_dec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt <= '0;
         idx     <= '0;
         seg_r   <= '0;
         dig_r   <= '0;
      end else begin
         seg_r <= seg_dec;
         dig_r <= dig_nxt;
         if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            ref_cnt <= ref_cnt + 1'b1;
         end
      end
   end

   assign link.bcd_out     = bcd_r;
   assign link.frame_valid = valid_r;
   assign link.frame_err   = err_r;
   assign link.seg         = seg_r;
   assign link.dig_en      = dig_r;

endmodule

// File: tb/tb_display_rx.sv
// Self-checking bench for display_rx: frame table with a pulse scoreboard,
// plus reset-mid-frame and display scan sequences.
module tb_display_rx;
   import calc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   display_rx_if #(.DIGITS(4)) link ();

   display_rx #(.FRAME_BITS(16), .DIGITS(4), .REFRESH_DIV(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
                                7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

   typedef struct {
      bit          valid;
      logic [15:0] data;
      int          k;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      int          nbits;
      logic [31:0] pattern;
      bit          same;
      bit          exp_valid;
   } vec_t;
   vec_t vecs[7];

   logic [15:0] exp_bcd;
   logic        pv, pe;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every result pulse pops one expectation.
   always @(negedge clk) begin
      if (rst) begin
         exp_bcd = '0;
         pv = 1'b0;
         pe = 1'b0;
      end else begin
         if (link.frame_valid || link.frame_err) begin
            chk("pulse_exclusive", {31'd0, link.frame_valid & link.frame_err}, 32'd0);
            chk("pulse_width", {31'd0, pv | pe}, 32'd0);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: valid=%0b err=%0b with empty scoreboard", link.frame_valid, link.frame_err);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("pulse_kind", {31'd0, link.frame_valid}, {31'd0, e.valid});
               chk("pulse_latency", cyc, e.k + 3);
               if (e.valid) exp_bcd = e.data;
               chk("bcd_out", {16'd0, link.bcd_out}, {16'd0, exp_bcd});
            end
         end
         pv = link.frame_valid;
         pe = link.frame_err;
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 12) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL missing_pulse: %0d expected pulses not seen", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic send_frame(input int nbits, input logic [31:0] pattern, input bit same, input bit valid);
      exp_t e;
      for (int i = nbits - 1; i >= 0; i--) begin
         link.data_in = pattern[i];
         repeat (3) @(negedge clk);
         link.data_clk = 1'b1;
         if (same && i == 0) begin
            link.data_ready = 1'b1;
            e.valid = valid; e.data = pattern[15:0]; e.k = cyc + 1;
            sbq.push_back(e);
         end
         repeat (3) @(negedge clk);
         link.data_clk   = 1'b0;
         link.data_ready = 1'b0;
      end
      if (!(same && nbits > 0)) begin
         repeat (3) @(negedge clk);
         link.data_ready = 1'b1;
         e.valid = valid; e.data = pattern[15:0]; e.k = cyc + 1;
         sbq.push_back(e);
         repeat (3) @(negedge clk);
         link.data_ready = 1'b0;
      end
      repeat (3) @(negedge clk);
      drain();
   endtask

   task automatic wait_digit0(output bit found);
      logic [3:0] prev;
      found = 1'b0;
      prev  = link.dig_en;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (prev != 4'b0001 && link.dig_en == 4'b0001) found = 1'b1;
         prev = link.dig_en;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL scan_start: dig_en never entered 0001 (now %b)", link.dig_en);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_bcd_out", {16'd0, link.bcd_out}, 32'd0);
      chk("rst_frame_valid", {31'd0, link.frame_valid}, 32'd0);
      chk("rst_frame_err", {31'd0, link.frame_err}, 32'd0);
      chk("rst_seg", {25'd0, link.seg}, 32'd0);
      chk("rst_dig_en", {28'd0, link.dig_en}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      vecs[0] = '{0,  32'h0,     1'b0, 1'b0};
      vecs[1] = '{16, 32'h1234,  1'b0, 1'b1};
      vecs[2] = '{15, 32'h0FFF,  1'b0, 1'b0};
      vecs[3] = '{16, 32'h4321,  1'b0, 1'b1};
      vecs[4] = '{17, 32'h1ABCD, 1'b0, 1'b0};
      vecs[5] = '{16, 32'h5678,  1'b1, 1'b1};
      vecs[6] = '{16, 32'h00A5,  1'b0, 1'b1};

      rst = 1'b1;
      link.data_in = 1'b0;
      link.data_clk = 1'b0;
      link.data_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      @(negedge clk);
      chk("first_dig_en", {28'd0, link.dig_en}, 32'h1);
      chk("first_seg", {25'd0, link.seg}, {25'd0, seg_tab[0]});

      for (int v = 0; v < 7; v++) begin
         send_frame(vecs[v].nbits, vecs[v].pattern, vecs[v].same, vecs[v].exp_valid);
         if (v == 1) begin
            wait_digit0(found);
            if (found) chk("seg_digit0_1234", {25'd0, link.seg}, {25'd0, seg_tab[4]});
         end
      end

      // Full scan of 0x00A5: 5, blank, 0, 0, each digit held 16 cycles.
      wait_digit0(found);
      if (found) begin
         for (int i = 0; i < 64; i++) begin
            logic [3:0] nib;
            logic [15:0] val;
            val = 16'h00A5;
            nib = val[4*(i/16) +: 4];
            chk("scan_dig_en", {28'd0, link.dig_en}, 32'(1 << (i / 16)));
            chk("scan_seg", {25'd0, link.seg}, {25'd0, seg_tab[nib]});
            @(negedge clk);
         end
      end

      // Reset in the middle of a frame, then a full frame must be accepted.
      for (int i = 15; i >= 8; i--) begin
         link.data_in = 1'b1;
         repeat (3) @(negedge clk);
         link.data_clk = 1'b1;
         repeat (3) @(negedge clk);
         link.data_clk = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send_frame(16, 32'h9876, 1'b0, 1'b1);
      chk("bcd_after_reset", {16'd0, link.bcd_out}, 32'h9876);

      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
